bist_sig_check: RTL
===================

# bist_sig_check

Session controller and signature checker directly downstream of the 4-bit serial-input signature register (SISR, polynomial x^4+x+1). It frames a test session of a programmable number of serial bits and samples the SISR signature exactly when the last bit has been absorbed. It compares the signature with an expected value and keeps saturating session and failure counts for the BIST status path.

## Interface
Parameters:
- LW, 8: width of `len` and of the internal bit counter.
- CW, 8: width of `sess_cnt` and `fail_cnt`.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_b  in  1  asynchronous, active-low reset, shared with the SISR.
- start  in  1  session request; accepted only in IDLE.
- len  in  LW  number of serial bits in the session, sampled with `start`; 0 means 2^LW.
- exp  in  4  expected signature, sampled with `start`.
- sig  in  4  SISR parallel output `q[3:0]`.
- clr_cnt  in  1  synchronous clear of `sess_cnt` and `fail_cnt`.
- busy  out  1  session in progress.
- done  out  1  one-cycle pulse when the signature has been sampled.
- pass  out  1  last session's result (sig_cap == exp); held until the next `done`.
- sig_cap  out  4  signature captured at the end of the last session; held.
- sess_cnt  out  CW  completed sessions, saturating at 2^CW-1.
- fail_cnt  out  CW  failed sessions, saturating at 2^CW-1.

## Operation
- The FSM has two states, IDLE and RUN. Reset state is IDLE.
- Reset values: busy=0, done=0, pass=0, sig_cap=0, sess_cnt=0, fail_cnt=0. The bit counter and the `exp` register are also 0.
- IDLE:
  - `start`=1 at a rising edge E0 loads the counter with `len` and registers `exp`, then moves to RUN.
  - With `start`=0 the block stays in IDLE.
- Session framing:
  - The SISR bit presented on its serial input at E0 is stream bit 0.
  - Bits 0..N-1 are absorbed at edges E0..E(N-1), where N = len (or 2^LW if len=0).
- RUN:
  - The counter decrements at each edge.
  - At edge E(N), `sig` is captured into `sig_cap`. At the same edge `pass` = (sig == registered exp) and `done` = 1, and the FSM returns to IDLE.
  - Also at E(N), `sess_cnt` increments, and `fail_cnt` increments if the signatures mismatch. Both counters saturate.
- `start` while in RUN is ignored; `len`/`exp` changes during RUN have no effect.
- `start` while `done`=1 (already IDLE) is accepted, which gives back-to-back sessions with a one-cycle gap.
- `clr_cnt`:
  - Zeroes both counters at the next edge in any state.
  - If it coincides with a session end, the clear wins: counters become 0, and `sig_cap`/`pass`/`done` still update.
- The block never resets or controls the SISR. Seeding the SISR (via the shared `rst_b`, which gives signature 0) is the system's responsibility.
- Asynchronous reset mid-session: the block returns immediately to IDLE with all outputs at their reset values, and the partial session is discarded.

## Timing
- `busy` is 1 in the cycles after E0 through E(N-1). It falls at E(N), the same edge at which `done` rises.
- Latency from `start` accepted at E0 to `done` high is N cycles. `done` is high for exactly one cycle.
- `sig_cap`, `pass` and both counters change only at session-end edges, at `clr_cnt` edges, or on reset.
- Minimum session-to-session spacing is N+1 cycles.

## Test plan
- Reset, then drive serial 1,0,0,0 into the SISR with start at E0, len=4, exp=4'h8. Required: done=1 after E4, sig_cap=4'h8, pass=1, sess_cnt=1, fail_cnt=0, busy high exactly 4 cycles.
- Same stream extended with one more 0, len=5, exp=4'h8. Required: sig_cap=4'h3, pass=0, fail_cnt increments to 1.
- Assert `start` during RUN with a different len/exp. Required: ignored, and the original session completes on schedule with the original exp.
- Back-to-back sessions: assert start during the `done` cycle, len=1. Required: the second done comes 1 cycle after acceptance, and sess_cnt advances by 2 overall.
- len=0 with a 256-bit all-zero stream from a reset SISR. Required: done after 256 cycles, sig_cap=4'h0; with exp=0, pass=1.
- Pull `rst_b` low mid-session, then saturate the counters (sess_cnt=255 plus another session) and pulse clr_cnt at a session end.
  - Reset: all outputs return to 0 and there is no done.
  - Saturation: sess_cnt stays at 255.
  - Clear at session end: counters read 0 while `done`/`sig_cap` still update.

Source files
------------

// File: rtl/bist_sig_check.sv
// ---------------------------------------------------------------------------
// bist_sig_check
//
// Session controller and signature checker placed directly after a 4-bit
// serial-input signature register (SISR, x^4+x+1). It frames a test session
// of a programmable number of serial bits. When the last bit has been
// absorbed it samples the SISR signature and compares it with an expected
// value. It also keeps saturating counts of sessions and of failed sessions.
//
// Parameters:
//   LW        width of len and of the internal bit counter
//   CW        width of sess_cnt / fail_cnt
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_b      in   asynchronous active-low reset (shared with the SISR)
//   start      in   session request, accepted only in IDLE
//   len        in   session length in bits, sampled with start (0 = 2^LW)
//   exp        in   expected signature, sampled with start
//   sig        in   SISR parallel output q[3:0]
//   clr_cnt    in   synchronous clear of sess_cnt / fail_cnt
//   busy       out  session in progress
//   done       out  one-cycle pulse when the signature is sampled
//   pass       out  result of the last session, held until the next done
//   sig_cap    out  signature captured at the last session end, held
//   sess_cnt   out  completed sessions, saturating
//   fail_cnt   out  failed sessions, saturating
//   dbg_state  out  FSM state (0 = IDLE, 1 = RUN) for observation
//
// Handshake: start is a level sampled on a rising edge. It is taken only
// when the FSM is IDLE, which includes the cycle in which done is high.
// A start seen while RUN is dropped rather than queued.
// ---------------------------------------------------------------------------
module bist_sig_check #(
  parameter int LW = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic [LW-1:0] len,
  input  logic [3:0]    exp,
  input  logic [3:0]    sig,
  input  logic          clr_cnt,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [3:0]    sig_cap,
  output logic [CW-1:0] sess_cnt,
  output logic [CW-1:0] fail_cnt,
  output logic          dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [LW-1:0] CNT_ONE = LW'(1);
  localparam logic [CW-1:0] SAT_ONE = CW'(1);
  localparam logic [CW-1:0] SAT_MAX = '1;

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [3:0]    exp_q, exp_d;
  logic [3:0]    sig_cap_q, sig_cap_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;
  logic [CW-1:0] sess_q, sess_d;
  logic [CW-1:0] fail_q, fail_d;
  logic          sess_end;
  logic          sig_match;

  // The counter holds N after the accepting edge E0 and reaches 1 just
  // before edge E(N). A len of 0 wraps through 2^LW-1 down to 1, which
  // gives the full 2^LW session with no special case.
  assign sess_end  = (state_q == RUN) && (cnt_q == CNT_ONE);
  assign sig_match = (sig == exp_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    sig_cap_d = sig_cap_q;
    pass_d    = pass_q;
    done_d    = 1'b0;
    sess_d    = sess_q;
    fail_d    = fail_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = len;
          exp_d   = exp;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (sess_end) begin
          state_d   = IDLE;
          sig_cap_d = sig;
          pass_d    = sig_match;
          done_d    = 1'b1;
          if (sess_q != SAT_MAX) begin
            sess_d = sess_q + SAT_ONE;
          end
          if (!sig_match && (fail_q != SAT_MAX)) begin
            fail_d = fail_q + SAT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A clear overrides any increment made at the same edge.
    if (clr_cnt) begin
      sess_d = '0;
      fail_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      exp_q     <= '0;
      sig_cap_q <= '0;
      pass_q    <= 1'b0;
      done_q    <= 1'b0;
      sess_q    <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      sig_cap_q <= sig_cap_d;
      pass_q    <= pass_d;
      done_q    <= done_d;
      sess_q    <= sess_d;
      fail_q    <= fail_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign pass      = pass_q;
  assign sig_cap   = sig_cap_q;
  assign sess_cnt  = sess_q;
  assign fail_cnt  = fail_q;
  assign dbg_state = state_q;

endmodule
